// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Purpose  : State encodings and demux select codes shared by the clock UI.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    localparam logic SEL_HOURS   = 1'b0;
    localparam logic SEL_MINUTES = 1'b1;

endpackage

`default_nettype wire

// File: rtl/time_set_controller_if.sv
// ============================================================================
// Module   : time_set_controller_if
// Purpose  : Button/tick inputs and demux-facing outputs of the time-set UI.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface time_set_controller_if;
    import clock_pkg::*;

    logic   tick;
    logic   mode_btn;
    logic   adj_btn;
    logic   sel;
    logic   adj_pulse;
    logic   run_en;
    logic   blink;
    state_t set_state;

    modport master (
        output tick, mode_btn, adj_btn,
        input  sel, adj_pulse, run_en, blink, set_state
    );

    modport slave (
        input  tick, mode_btn, adj_btn,
        output sel, adj_pulse, run_en, blink, set_state
    );
endinterface

`default_nettype wire

// File: rtl/time_set_controller_btn_edge_detect.sv
// ============================================================================
// Module   : btn_edge_detect
// Purpose  : Registered rising-edge detector for a debounced button level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      o_rise
);
    logic r_prev;
    logic r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_prev  <= i_btn;
            r_valid <= 1'b1;
        end
    end

    // r_prev only counts as a real "low" once it holds a post-reset sample,
    // so a button held through reset is not mistaken for a fresh press.
    assign o_rise = i_btn & ~r_prev & r_valid;

endmodule

`default_nettype wire

// File: rtl/time_set_controller.sv
// ============================================================================
// Module   : time_set_controller
// Purpose  : MODE/ADJ front end: set-mode FSM, adjust pulses with auto-repeat,
//            blink strobe. Optional macro SET_TIMEOUT_EN adds idle return to RUN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module time_set_controller
    import clock_pkg::*;
#(
    parameter int TW           = 14,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int BLINK_HALF   = 250,
    parameter int TIMEOUT      = 10000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    time_set_controller_if.slave  bus
);

    localparam logic [TW-1:0] c_cnt_max      = {TW{1'b1}};
    localparam logic [TW-1:0] c_repeat_delay = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] c_repeat_rate  = TW'(REPEAT_RATE);
    localparam logic [TW-1:0] c_blink_half   = TW'(BLINK_HALF);

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || BLINK_HALF < 1 || TIMEOUT < 1 ||
        REPEAT_DELAY > (2**TW - 1) || REPEAT_RATE > (2**TW - 1) ||
        BLINK_HALF > (2**TW - 1) || TIMEOUT > (2**TW - 1)) begin : g_param_check
        $error("time_set_controller: tick parameters must be 1 .. 2**TW-1");
    end

    state_t        r_state;
    logic          r_sel;
    logic          r_run_en;
    logic          r_adj_pulse;
    logic          r_blink;
    logic          r_armed;
    logic          r_hold;
    logic [TW-1:0] r_rpt_cnt;
    logic [TW-1:0] r_blink_cnt;

    state_t        w_state_next;
    logic          w_sel_next;
    logic          w_run_en_next;
    logic          w_state_chg;
    logic          w_mode_rise;
    logic          w_adj_rise;
    logic          w_in_set;
    logic          w_edge_pulse;
    logic          w_rpt_reach;
    logic          w_fire;
    logic          w_timeout_hit;
    logic [TW-1:0] w_rpt_limit;
    logic [TW-1:0] w_rpt_inc;
    logic [TW-1:0] w_blink_inc;

    btn_edge_detect u_mode_edge (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (bus.mode_btn),
        .o_rise (w_mode_rise)
    );

    btn_edge_detect u_adj_edge (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (bus.adj_btn),
        .o_rise (w_adj_rise)
    );

    assign w_in_set    = (r_state != ST_RUN);
    assign w_rpt_limit = r_armed ? c_repeat_rate : c_repeat_delay;
    assign w_rpt_inc   = (r_rpt_cnt == c_cnt_max) ? r_rpt_cnt : r_rpt_cnt + 1'b1;
    assign w_blink_inc = (r_blink_cnt == c_cnt_max) ? r_blink_cnt : r_blink_cnt + 1'b1;

`ifdef SET_TIMEOUT_EN
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

    logic [TW-1:0] r_idle_cnt;
    logic          w_idle_tick;
    logic [TW-1:0] w_idle_inc;

    assign w_idle_tick   = w_in_set & bus.tick & ~bus.mode_btn & ~bus.adj_btn;
    assign w_idle_inc    = (r_idle_cnt == c_cnt_max) ? r_idle_cnt : r_idle_cnt + 1'b1;
    assign w_timeout_hit = w_idle_tick & (w_idle_inc == c_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (w_state_chg || w_mode_rise || w_adj_rise || !w_in_set) begin
            r_idle_cnt <= '0;
        end else if (w_idle_tick) begin
            r_idle_cnt <= w_idle_inc;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:     if (w_mode_rise) w_state_next = ST_SET_HR;
            ST_SET_HR:  if (w_mode_rise) w_state_next = ST_SET_MIN;
            ST_SET_MIN: if (w_mode_rise) w_state_next = ST_RUN;
            default:    w_state_next = ST_RUN;
        endcase
        if (w_timeout_hit) begin
            w_state_next = ST_RUN;
        end
        w_state_chg   = (w_state_next != r_state);
        w_sel_next    = (w_state_next == ST_SET_MIN) ? SEL_MINUTES : SEL_HOURS;
        w_run_en_next = (w_state_next == ST_RUN);
    end

    // A MODE edge in the same clk swallows the ADJ edge.
    assign w_edge_pulse = w_in_set & w_adj_rise & ~w_mode_rise;
    assign w_rpt_reach  = r_hold & bus.adj_btn & bus.tick & w_in_set & ~w_state_chg &
                          (w_rpt_inc == w_rpt_limit);
    assign w_fire       = w_edge_pulse | (w_rpt_reach & ~r_adj_pulse);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_sel       <= SEL_HOURS;
            r_run_en    <= 1'b1;
            r_adj_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_run_en    <= w_run_en_next;
            r_adj_pulse <= w_fire;
        end
    end

    // r_hold marks a press that began in the current SET state; only such a
    // press may auto-repeat, so a hold carried across a MODE press stays silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt <= '0;
            r_armed   <= 1'b0;
            r_hold    <= 1'b0;
        end else if (w_state_chg || !bus.adj_btn || !w_in_set) begin
            r_rpt_cnt <= '0;
            r_armed   <= 1'b0;
            r_hold    <= 1'b0;
        end else if (w_edge_pulse) begin
            r_rpt_cnt <= '0;
            r_armed   <= 1'b0;
            r_hold    <= 1'b1;
        end else if (r_hold && bus.tick) begin
            if (w_rpt_inc == w_rpt_limit) begin
                if (!r_adj_pulse) begin
                    r_rpt_cnt <= '0;
                    r_armed   <= 1'b1;
                end
            end else begin
                r_rpt_cnt <= w_rpt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_state_chg || w_fire || !w_in_set) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (bus.tick) begin
            if (w_blink_inc == c_blink_half) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= w_blink_inc;
            end
        end
    end

    assign bus.set_state = r_state;
    assign bus.sel       = r_sel;
    assign bus.run_en    = r_run_en;
    assign bus.adj_pulse = r_adj_pulse;
    assign bus.blink     = r_blink;

endmodule

`default_nettype wire
